// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared types and helpers for the serial adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Cycle counter width: max(1, clog2(n)).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
// full_adder_cell : combinational 1-bit full adder, one link of the ripple chain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic w_p;

  assign w_p    = a_i ^ b_i;
  assign sum_o  = w_p ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & w_p);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : multi-cycle LSB-first adder, BITS_PER_CYCLE bits per clock,
// valid/ready on both sides. Optional subtract/overflow: SERIAL_ADDER_SUB_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  generate
    if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("serial_adder: BITS_PER_CYCLE must be >=1 and divide WIDTH exactly");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_SUB_EN
  logic             ovf_q, ovf_d;
`endif

  logic [BITS_PER_CYCLE:0]   w_c;
  logic [BITS_PER_CYCLE-1:0] w_ps;
  logic [WIDTH-1:0]          w_res_shift;

  assign w_c[0] = carry_q;

  generate
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
      full_adder_cell u_cell (
        .a_i    (a_q[i]),
        .b_i    (b_q[i]),
        .cin_i  (w_c[i]),
        .sum_o  (w_ps[i]),
        .cout_o (w_c[i+1])
      );
    end
  endgenerate

  // Partial sums enter at the MSB end so after N shifts chunk 0 sits at the LSB.
  generate
    if (N == 1) begin : g_res_single
      assign w_res_shift = w_ps;
    end else begin : g_res_multi
      assign w_res_shift = {w_ps, res_q[WIDTH-1:BITS_PER_CYCLE]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
`ifdef SERIAL_ADDER_SUB_EN
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        carry_d = w_c[BITS_PER_CYCLE];
        res_d   = w_res_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = w_res_shift;
          cout_d  = w_c[BITS_PER_CYCLE];
`ifdef SERIAL_ADDER_SUB_EN
          // Signed overflow: carry into the MSB differs from carry out of it.
          ovf_d   = w_c[BITS_PER_CYCLE] ^ w_c[BITS_PER_CYCLE-1];
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
  assign ovf       = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : self-checking bench for serial_adder (three configurations).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  iv, ordy, cin_v;
  wire  [2:0]  ir, ov, co, bsy;
  logic [7:0]  a0, b0;
  logic [15:0] a1, b1;
  logic [3:0]  a2, b2;
  wire  [7:0]  s0;
  wire  [15:0] s1;
  wire  [3:0]  s2;
`ifdef SERIAL_ADDER_SUB_EN
  logic [2:0]  sub_v;
  wire  [2:0]  of;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a0), .b(b0), .cin(cin_v[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v[0]), .ovf(of[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .busy(bsy[0]));

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a1), .b(b1), .cin(cin_v[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v[1]), .ovf(of[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .busy(bsy[1]));

  serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a2), .b(b2), .cin(cin_v[2]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v[2]), .ovf(of[2]),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wid(input int d);
    return (d == 0) ? 8 : (d == 1) ? 16 : 4;
  endfunction

  function automatic int ncyc(input int d);
    return (d == 0) ? 8 : (d == 1) ? 4 : 1;
  endfunction

  function automatic logic [63:0] get_sum(input int d);
    return (d == 0) ? 64'(s0) : (d == 1) ? 64'(s1) : 64'(s2);
  endfunction

  task automatic drive_ops(input int d, input logic [63:0] a, input logic [63:0] b,
                           input logic ci, input logic sb);
    case (d)
      0:       begin a0 = a[7:0];  b0 = b[7:0];  end
      1:       begin a1 = a[15:0]; b1 = b[15:0]; end
      default: begin a2 = a[3:0];  b2 = b[3:0];  end
    endcase
    cin_v[d] = ci;
`ifdef SERIAL_ADDER_SUB_EN
    sub_v[d] = sb;
`endif
  endtask

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  task automatic model(input int d, input logic [63:0] a_in, input logic [63:0] b_in,
                       input logic ci, input logic sb,
                       output logic [63:0] es, output logic ec, output logic eo);
    int          w;
    logic [63:0] m, a, b, t;
    longint      sa, sbv, r, lim;
    w   = wid(d);
    m   = (64'd1 << w) - 64'd1;
    a   = a_in & m;
    b   = b_in & m;
    sa  = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sbv = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    lim = longint'(1) << (w - 1);
    if (sb) begin
      es = (a - b) & m;
      ec = (a >= b);
      r  = sa - sbv;
    end else begin
      t  = a + b + 64'(ci);
      es = t & m;
      ec = t[w];
      r  = sa + sbv + longint'(ci);
    end
    eo = (r >= lim) || (r < -lim);
  endtask

  // Starts and ends on a negative edge.
  task automatic run_op(input int d, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic sb_in, input int hold);
    logic [63:0] es;
    logic        ec, eo, sb;
    int          n;
    n  = ncyc(d);
    sb = sb_in & HAS_SUB;
    model(d, a, b, ci, sb, es, ec, eo);
    chk("idle_in_ready", ir[d], 1'b1);
    drive_ops(d, a, b, ci, sb);
    iv[d]   = 1'b1;
    ordy[d] = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    iv[d] = 1'b0;
    drive_ops(d, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    chk("run_ir_ov_busy", {ir[d], ov[d], bsy[d]}, 3'b001);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("latency_out_valid", ov[d], (k == n));
    end
    chk("done_busy_ir", {bsy[d], ir[d]}, 2'b10);
    chk("sum", get_sum(d), es);
    chk("cout", co[d], ec);
`ifdef SERIAL_ADDER_SUB_EN
    chk("ovf", of[d], eo);
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_ov_ir", {ov[d], ir[d]}, 2'b10);
      chk("hold_sum", {co[d], get_sum(d)}, {ec, es});
    end
    ordy[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_ir_ov_busy", {ir[d], ov[d], bsy[d]}, 3'b100);
    chk("idle_sum_held", {co[d], get_sum(d)}, {ec, es});
  endtask

  initial begin
    logic [63:0] es;
    logic        ec, eo, seen;
    int          c;

    rst  = 1'b1;
    iv   = '0;
    ordy = '1;
    for (int d = 0; d < 3; d++) drive_ops(d, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ir_ov_busy", {ir[d], ov[d], bsy[d]}, 3'b100);
      chk("reset_sum_cout", {co[d], get_sum(d)}, 65'd0);
    end

    // Directed cases.
    run_op(0, 64'h3C, 64'h05, 1'b0, 1'b0, 0);
    run_op(0, 64'hFF, 64'h01, 1'b0, 1'b0, 0);
    run_op(0, 64'hFF, 64'hFF, 1'b1, 1'b0, 1);
    run_op(1, 64'h1234, 64'hEDCC, 1'b0, 1'b0, 5);
    run_op(2, 64'hF, 64'h1, 1'b0, 1'b0, 0);
`ifdef SERIAL_ADDER_SUB_EN
    run_op(0, 64'h80, 64'h01, 1'b0, 1'b1, 0);
    run_op(0, 64'h05, 64'h07, 1'b1, 1'b1, 0);
`endif

    // Randomized operations.
    for (int i = 0; i < 12; i++)
      run_op(0, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    for (int i = 0; i < 12; i++)
      run_op(1, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    for (int i = 0; i < 8; i++)
      run_op(2, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 1)));

    // Reset during RUN aborts the operation.
    drive_ops(0, 64'hAA, 64'h77, 1'b1, 1'b0);
    iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ir_ov_busy", {ir[0], ov[0], bsy[0]}, 3'b100);
    chk("midrst_sum_cout", {co[0], get_sum(0)}, 65'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      seen |= ov[0];
    end
    chk("midrst_no_out_valid", seen, 1'b0);
    run_op(0, 64'h10, 64'h20, 1'b0, 1'b0, 0);

    // Back-to-back issue: in_valid held through DONE is taken only in IDLE.
    drive_ops(0, 64'h5A, 64'h33, 1'b0, 1'b0);
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    c = 0;
    while (!ov[0] && c < 100) begin
      @(posedge clk);
      c++;
      @(negedge clk);
    end
    chk("tp_first_latency", 64'(c), 64'd8);
    chk("tp_first_sum", {co[0], get_sum(0)}, {1'b0, 64'h8D});
    model(0, 64'hC4, 64'h9B, 1'b1, 1'b0, es, ec, eo);
    drive_ops(0, 64'hC4, 64'h9B, 1'b1, 1'b0);
    iv[0] = 1'b1;
    @(posedge clk);
    c++;
    @(negedge clk);
    chk("tp_not_accepted_in_done", {ir[0], bsy[0]}, 2'b10);
    @(posedge clk);
    c++;
    @(negedge clk);
    iv[0] = 1'b0;
    chk("tp_accepted_busy", bsy[0], 1'b1);
    chk("tp_issue_interval", 64'(c), 64'd10);
    c = 0;
    while (!ov[0] && c < 100) begin
      @(posedge clk);
      c++;
      @(negedge clk);
    end
    chk("tp_second_latency", 64'(c), 64'd8);
    chk("tp_second_sum", {co[0], get_sum(0)}, {ec, es});
    @(posedge clk);
    @(negedge clk);
    chk("tp_back_to_idle", ir[0], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder built from a chain of 1-bit full-adder cells.
- Processes BITS_PER_CYCLE operand bits per clock, LSB first, and carries between cycles in a register.
- Successor to the fixed 1-bit combinational full adder: arbitrary width, area/latency trade-off, valid/ready handshakes.
- Sits between operand producers and result consumers in the datapath test builds.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=1).
- BITS_PER_CYCLE, 1, bits added per clock; must divide WIDTH exactly, otherwise elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand-side valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result sum.
- cout  output  1  carry-out of MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Constant N = WIDTH/BITS_PER_CYCLE. Cycle counter width is max(1, clog2(N)).
- States:
  - IDLE: in_ready=1, out_valid=0, busy=0. On in_valid=1, capture a, b, cin into shift registers and the carry register, clear the counter, go to RUN.
  - RUN: in_ready=0, out_valid=0, busy=1. Each edge adds the low BITS_PER_CYCLE bits of the A/B shift registers plus the carry register through the cell chain. The partial sum shifts into the result register from the MSB end, A/B shift right by BITS_PER_CYCLE, the carry register takes the chain carry-out, and the counter increments. On the edge where counter==N-1, load sum and cout from the final values and go to DONE.
  - DONE: in_ready=0, out_valid=1, busy=1. sum/cout are stable. When out_ready=1, go to IDLE.
- Latency:
  - The acceptance edge is edge 0. out_valid is high after edge N, i.e. exactly N cycles later.
  - Minimum issue interval is N+2 cycles, because in_ready is low in DONE. An in_valid coinciding with out_ready in DONE is not accepted; it is accepted on the following cycle in IDLE.
  - WIDTH==BITS_PER_CYCLE (N=1): RUN lasts one cycle.
- Output registers:
  - sum and cout change only on DONE entry.
  - They hold their value through IDLE until the next DONE entry.
  - Operand inputs are sampled only at the acceptance edge; changes in RUN/DONE are ignored.
- Arithmetic:
  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Wrap example: all-ones + 1 gives sum=0, cout=1.
- Reset:
  - On a clock edge with rst=1: state=IDLE, out_valid=0, in_ready=1 (after the edge), busy=0, sum=0, cout=0, counter=0, shift and carry registers cleared.
  - Reset mid-RUN or mid-DONE aborts the operation; no out_valid is produced for it.
  - rst has priority over all handshakes.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled at acceptance.
  - sub=1 computes a - b: captures ~b and forces the initial carry to 1, ignoring cin. cout=1 means no borrow.
  - Adds output ovf (1 bit): signed two's-complement overflow, loaded with sum on DONE entry, reset 0.
- When undefined: no sub or ovf ports; add-only behaviour as above.

Decomposition:
- Package serial_adder_pkg:
  - state enum (IDLE, RUN, DONE), 2 bits.
  - a function computing the counter width from N.
- Sub-module full_adder_cell: combinational 1-bit a/b/cin -> sum/cout. Instantiated BITS_PER_CYCLE times in a ripple chain via generate.

Test Plan:
- WIDTH=8, BPC=1: a=0x3C, b=0x05, cin=0, out_ready=1 -> out_valid 8 cycles after acceptance; sum=0x41, cout=0; in_ready returns 1 the cycle after DONE.
- WIDTH=8, BPC=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- WIDTH=16, BPC=4: a=0x1234, b=0xEDCC, cin=0 -> after 4 cycles sum=0x0000, cout=1. Hold out_ready=0 for 5 cycles -> out_valid and sum stay stable, in_ready stays 0.
- Assert rst at RUN cycle 3 of a WIDTH=8 operation -> no out_valid; after reset sum=0, cout=0, in_ready=1. The next operation, 0x10+0x20, completes with sum=0x30.
- In DONE, hold in_valid=1 with out_ready=1 -> the new operand is accepted only on the next cycle (IDLE). Measured throughput is N+2 cycles per operation.
- With SERIAL_ADDER_SUB_EN, WIDTH=8: sub=1, a=0x80, b=0x01 -> sum=0x7F, ovf=1, cout=1. sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0.
